// File: rtl/fetch_seq_pkg.sv
// -----------------------------------------------------------------------------
// fetch_seq_pkg
// Shared definitions for the instruction-fetch sequencer.
//   state_t    : sequencer state encoding (IDLE / READ / INC)
//   WORD_W     : width of address, instruction and memory data words
//   WAIT_CNT_W : width of the READ-cycle counter
// -----------------------------------------------------------------------------
package fetch_seq_pkg;

    localparam int WORD_W     = 16;
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_INC  = 2'd2
    } state_t;

endpackage : fetch_seq_pkg

// File: rtl/fetch_seq_wait_timer.sv
// -----------------------------------------------------------------------------
// fetch_wait_timer
// Counts completed READ cycles for the fetch sequencer.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : restart the count at zero (new fetch accepted)
//   i_advance      : another READ cycle completed without finishing the fetch
//   o_min_met      : n = cnt+1 has reached MIN_WAIT (data may be sampled)
//   o_timed_out    : n = cnt+1 equals TIMEOUT (this edge aborts the fetch)
// -----------------------------------------------------------------------------
module fetch_wait_timer
    import fetch_seq_pkg::*;
#(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_min_met,
    output logic o_timed_out
);

    localparam logic [WAIT_CNT_W-1:0] MIN_CNT = WAIT_CNT_W'(MIN_WAIT);
    localparam logic [WAIT_CNT_W-1:0] TO_CNT  = WAIT_CNT_W'(TIMEOUT);

    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_n;

    // r_cnt never exceeds TIMEOUT-1 (<=254), so n cannot wrap.
    assign w_n         = r_cnt + WAIT_CNT_W'(1);
    assign o_min_met   = (w_n >= MIN_CNT);
    assign o_timed_out = (w_n == TO_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_advance) begin
            r_cnt <= w_n;
        end
    end

endmodule : fetch_wait_timer

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq
// Instruction-fetch sequencer placed after the program counter. A fetch
// request captures the PC into the MAR, runs a wait-state-aware memory read,
// loads the returned word into the IR and strobes the PC to increment.
//
// Handshake: i_fetch_req is a level request looked at only in IDLE; it is
// accepted on the edge where it is high in IDLE and is never queued. During
// READ the memory holds i_mem_wait high to extend the cycle; data is taken on
// the first edge with i_mem_wait low once MIN_WAIT READ cycles have elapsed.
//
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_fetch_req      : fetch request (IDLE only)
//   i_pc_in          : current PC value
//   o_mem_addr       : memory address, always the MAR
//   o_mem_rd         : memory read strobe (READ state)
//   i_mem_wait       : memory wait request
//   i_mem_data       : memory read data
//   o_ir, o_ir_valid : instruction register and its valid flag
//   o_pc_inc, o_done : one-cycle strobes in INC
//   o_busy           : high outside IDLE
//   o_bus_err        : sticky timeout flag, cleared by the next accepted fetch
//   o_state          : current sequencer state (debug visibility)
// -----------------------------------------------------------------------------
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fetch_req,
    input  logic [WORD_W-1:0] i_pc_in,
    output logic [WORD_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic              i_mem_wait,
    input  logic [WORD_W-1:0] i_mem_data,
    output logic [WORD_W-1:0] o_ir,
    output logic              o_ir_valid,
    output logic              o_pc_inc,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_bus_err,
    output state_t            o_state
);

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_mar;
    logic [WORD_W-1:0] r_ir;
    logic              r_ir_valid;
    logic              r_bus_err;

    logic w_clear;
    logic w_advance;
    logic w_min_met;
    logic w_timed_out;
    logic w_accept;
    logic w_capture;
    logic w_abort;

    fetch_wait_timer #(
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_clear),
        .i_advance   (w_advance),
        .o_min_met   (w_min_met),
        .o_timed_out (w_timed_out)
    );

    // Next-state and per-state strobes.
    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_advance = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        o_mem_rd  = 1'b0;
        o_pc_inc  = 1'b0;
        o_done    = 1'b0;
        o_busy    = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_fetch_req) begin
                    w_accept = 1'b1;
                    w_clear  = 1'b1;
                    w_next   = ST_READ;
                end
            end
            ST_READ: begin
                o_mem_rd = 1'b1;
                // Data wins over timeout when both occur on the same edge.
                if (w_min_met && !i_mem_wait) begin
                    w_capture = 1'b1;
                    w_next    = ST_INC;
                end else if (w_timed_out) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_INC: begin
                o_pc_inc = 1'b1;
                o_done   = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_mar      <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mar      <= i_pc_in;
                r_ir_valid <= 1'b0;
                r_bus_err  <= 1'b0;
            end
            if (w_capture) begin
                r_ir       <= i_mem_data;
                r_ir_valid <= 1'b1;
            end
            if (w_abort) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign o_mem_addr = r_mar;
    assign o_ir       = r_ir;
    assign o_ir_valid = r_ir_valid;
    assign o_bus_err  = r_bus_err;
    assign o_state    = r_state;

endmodule : fetch_seq

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  localparam int MIN_WAIT = 1;
  localparam int TIMEOUT  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        fetch_req;
  logic [15:0] pc_in;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wait;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic        pc_inc;
  logic        done;
  logic        busy;
  logic        bus_err;
  state_t      state;

  fetch_seq #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_fetch_req (fetch_req),
    .i_pc_in     (pc_in),
    .o_mem_addr  (mem_addr),
    .o_mem_rd    (mem_rd),
    .i_mem_wait  (mem_wait),
    .i_mem_data  (mem_data),
    .o_ir        (ir),
    .o_ir_valid  (ir_valid),
    .o_pc_inc    (pc_inc),
    .o_done      (done),
    .o_busy      (busy),
    .o_bus_err   (bus_err),
    .o_state     (state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];   // addresses expected at the start of each read
  int exp_inc = 0;
  int seen_inc = 0;
  logic prev_rd = 1'b0;
  logic [15:0] exp_ir = 16'h0000;
  logic [15:0] pc_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every read burst must start at the next queued address; count pc_inc.
  always @(negedge clk) begin
    if (pc_inc === 1'b1) seen_inc++;
    if (mem_rd === 1'b1 && prev_rd !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL addr_unexpected observed=%0h expected=none", mem_addr);
      end else begin
        chk("addr_start", {16'h0, mem_addr}, {16'h0, exp_q.pop_front()});
      end
    end
    prev_rd = mem_rd;
  end

  // ---------------- transaction model + driver ----------------
  // A fetch with `waits` leading wait cycles completes after
  // max(MIN_WAIT, waits+1) READ cycles, unless that exceeds TIMEOUT,
  // in which case it aborts after exactly TIMEOUT READ cycles.
  task automatic do_fetch(input logic [15:0] pc, input int waits,
                          input logic [15:0] data, input bit hold);
    int need;
    int len;
    bit to;
    need = (waits + 1 > MIN_WAIT) ? waits + 1 : MIN_WAIT;
    to   = (need > TIMEOUT);
    len  = to ? TIMEOUT : need;

    chk("idle_state", state, ST_IDLE);
    chk("idle_busy", busy, 0);
    pc_val = pc;
    pc_in = pc;
    fetch_req = 1'b1;
    exp_q.push_back(pc);
    tick();
    fetch_req = hold;
    pc_in = $urandom;   // must not matter once captured
    for (int k = 0; k < len; k++) begin
      chk("rd_mem_rd", mem_rd, 1);
      chk("rd_addr", {16'h0, mem_addr}, {16'h0, pc});
      chk("rd_busy", busy, 1);
      chk("rd_ir_valid", ir_valid, 0);
      if (k == 0) chk("rd_err_clr", bus_err, 0);
      mem_wait = (k < waits);
      mem_data = (k < waits) ? 16'($urandom) : data;
      tick();
    end
    mem_wait = 1'b0;
    pc_in = pc_val;
    if (to) begin
      chk("to_bus_err", bus_err, 1);
      chk("to_state", state, ST_IDLE);
      chk("to_mem_rd", mem_rd, 0);
      chk("to_pc_inc", pc_inc, 0);
      chk("to_done", done, 0);
      chk("to_ir", {16'h0, ir}, {16'h0, exp_ir});
      chk("to_ir_valid", ir_valid, 0);
    end else begin
      exp_ir = data;
      chk("inc_pc_inc", pc_inc, 1);
      chk("inc_done", done, 1);
      chk("inc_mem_rd", mem_rd, 0);
      chk("inc_busy", busy, 1);
      chk("inc_ir", {16'h0, ir}, {16'h0, data});
      chk("inc_ir_valid", ir_valid, 1);
      chk("inc_bus_err", bus_err, 0);
      exp_inc++;
      pc_val = pc_val + 16'd1;
      pc_in = pc_val;
      tick();
      chk("post_pc_inc", pc_inc, 0);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_ir_valid", ir_valid, 1);
      chk("post_addr", {16'h0, mem_addr}, {16'h0, pc});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    fetch_req = 1'b0;
    pc_in = 16'h0000;
    mem_wait = 1'b0;
    mem_data = 16'h0000;
    pc_val = 16'h0000;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_ir", {16'h0, ir}, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_addr", {16'h0, mem_addr}, 0);
    chk("rst_pc_inc", pc_inc, 0);
    chk("rst_state", state, ST_IDLE);

    // Zero-wait and wait-state fetches
    do_fetch(16'hFEFA, 0, 16'h1234, 1'b0);
    tick();
    do_fetch(16'h0100, 4, 16'hABCD, 1'b0);

    // Ten back-to-back fetches with fetch_req held high
    pc_val = 16'hFEFA;
    for (int i = 0; i < 10; i++) begin
      do_fetch(pc_val, 0, 16'($urandom), 1'b1);
    end
    fetch_req = 1'b0;
    chk("b2b_last_addr", {16'h0, mem_addr}, {16'h0, 16'hFF03});
    chk("b2b_pc_next", {16'h0, pc_val}, {16'h0, 16'hFF04});

    // Timeout, then the next fetch clears bus_err
    do_fetch(16'h2000, TIMEOUT + 3, 16'h5555, 1'b0);
    tick();
    chk("err_sticky", bus_err, 1);
    do_fetch(16'h2001, 1, 16'h6666, 1'b0);

    // Boundary: waits just below and at the timeout edge
    do_fetch(16'h3000, TIMEOUT - 1, 16'h7777, 1'b0);
    do_fetch(16'h3001, TIMEOUT, 16'h8888, 1'b0);

    // Randomized fetches
    for (int i = 0; i < 40; i++) begin
      do_fetch(16'($urandom), int'($urandom_range(0, TIMEOUT + 2)),
               16'($urandom), 1'($urandom_range(0, 1)));
      fetch_req = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Reset in the middle of a READ after two wait cycles
    chk("mid_idle", state, ST_IDLE);
    pc_in = 16'h1357;
    fetch_req = 1'b1;
    exp_q.push_back(16'h1357);
    tick();
    fetch_req = 1'b0;
    mem_wait = 1'b1;
    tick();
    tick();
    chk("mid_in_read", mem_rd, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_wait = 1'b0;
    exp_ir = 16'h0000;
    chk("mid_state", state, ST_IDLE);
    chk("mid_mem_rd", mem_rd, 0);
    chk("mid_ir", {16'h0, ir}, 0);
    chk("mid_ir_valid", ir_valid, 0);
    chk("mid_pc_inc", pc_inc, 0);
    chk("mid_done", done, 0);
    chk("mid_addr", {16'h0, mem_addr}, 0);
    tick();
    chk("mid_pc_inc2", pc_inc, 0);
    do_fetch(16'h4242, 2, 16'h9999, 1'b0);

    tick();
    tick();
    chk("inc_total", seen_inc, exp_inc);
    chk("addr_q_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_seq
